fp_compare_pipe: RTL

- Parametrised, pipelined comparator for FloPoCo-format floating-point words. Successor to the single-mode subtractor-based greater-than check.
- Compares natively, with no FPSub instance. Handles all exception classes, including signed zeros and NaN.
- Per-transaction opcode selects GT/GE/LT/LE/EQ/NE/MAX/MIN.
- Valid/tag travel alongside the data, with a clock-enable stall. Used by the ray/AABB slab tests (t-near/t-far max/min reductions) for any wE/wF.

---
 rtl/fp_cmp_pkg.sv | 33 +++
 rtl/fp_class_decode.sv | 43 ++++
 rtl/fp_compare_pipe.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_cmp_pkg
//  Description : Shared definitions for the FloPoCo floating-point comparator.
//                Opcode encodings, exception-field encodings and a helper
//                that returns the total FloPoCo word width for given WE/WF.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_cmp_pkg;

    // Operation codes carried with each transaction
    localparam logic [2:0] OP_GT  = 3'b000;
    localparam logic [2:0] OP_GE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_LE  = 3'b011;
    localparam logic [2:0] OP_EQ  = 3'b100;
    localparam logic [2:0] OP_NE  = 3'b101;
    localparam logic [2:0] OP_MAX = 3'b110;
    localparam logic [2:0] OP_MIN = 3'b111;

    // FloPoCo exception field (top two bits of every word)
    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    // Word layout: {exception[1:0], sign, exponent[WE-1:0], fraction[WF-1:0]}
    function automatic int fp_word_w(input int we, input int wf);
        return we + wf + 3;
    endfunction

endpackage : fp_cmp_pkg
`default_nettype wire

// File: rtl/fp_class_decode.sv
`default_nettype none
// ============================================================================
//  Module      : fp_class_decode
//  Description : Purely combinational classifier for one FloPoCo word.
//                Splits the word into class flags, sign and the unsigned
//                {exponent,fraction} magnitude. Only the exception field
//                decides the class; exponent/fraction of special words are
//                passed through untouched and must be ignored downstream.
//  Ports       : i_word     - FloPoCo word
//                o_is_zero  - exception field is zero
//                o_is_inf   - exception field is infinity
//                o_is_nan   - exception field is NaN
//                o_sign     - sign bit
//                o_mag      - {exponent,fraction}
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_class_decode
    import fp_cmp_pkg::*;
#(
    parameter int WE = 11,
    parameter int WF = 16
) (
    input  logic [fp_word_w(WE, WF)-1:0] i_word,
    output logic                         o_is_zero,
    output logic                         o_is_inf,
    output logic                         o_is_nan,
    output logic                         o_sign,
    output logic [WE+WF-1:0]             o_mag
);

    localparam int c_W = fp_word_w(WE, WF);

    logic [1:0] w_exc;

    assign w_exc     = i_word[c_W-1:c_W-2];
    assign o_is_zero = (w_exc == EXC_ZERO);
    assign o_is_inf  = (w_exc == EXC_INF);
    assign o_is_nan  = (w_exc == EXC_NAN);
    assign o_sign    = i_word[WE+WF];
    assign o_mag     = i_word[WE+WF-1:0];

endmodule : fp_class_decode
`default_nettype wire

// File: rtl/fp_compare_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_compare_pipe
//  Description : Pipelined FloPoCo floating-point comparator with per-op
//                selection of GT/GE/LT/LE/EQ/NE/MAX/MIN. Valid and tag
//                travel with the data; ce=0 freezes every register.
//                PIPE=2: stage 1 holds decoded operands and the magnitude
//                compare, stage 2 holds the op-dependent result.
//                PIPE=1: everything is combinational into one output stage.
//  Ports       : clk, rst_n (async, active low), ce
//                in_valid, op[2:0], inA, inB, in_tag   - request
//                out_valid, result, unordered, sel_val, out_tag - response
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int WE   = 11,
    parameter int WF   = 16,
    parameter int PIPE = 2,
    parameter int TAGW = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic [2:0]                   op,
    input  logic [fp_word_w(WE, WF)-1:0] inA,
    input  logic [fp_word_w(WE, WF)-1:0] inB,
    input  logic [TAGW-1:0]              in_tag,
    output logic                         out_valid,
    output logic                         result,
    output logic                         unordered,
    output logic [fp_word_w(WE, WF)-1:0] sel_val,
    output logic [TAGW-1:0]              out_tag
);

    localparam int c_W  = fp_word_w(WE, WF);
    localparam int c_MW = WE + WF;

    // ------------------------------------------------------------------
    // Front end: classify both operands and compare magnitudes
    // ------------------------------------------------------------------
    logic            w_a_zero, w_a_inf, w_a_nan, w_a_sign;
    logic            w_b_zero, w_b_inf, w_b_nan, w_b_sign;
    logic [c_MW-1:0] w_a_mag, w_b_mag;
    logic            w_mag_gt, w_mag_eq;

    fp_class_decode #(.WE(WE), .WF(WF)) u_dec_a (
        .i_word    (inA),
        .o_is_zero (w_a_zero),
        .o_is_inf  (w_a_inf),
        .o_is_nan  (w_a_nan),
        .o_sign    (w_a_sign),
        .o_mag     (w_a_mag)
    );

    fp_class_decode #(.WE(WE), .WF(WF)) u_dec_b (
        .i_word    (inB),
        .o_is_zero (w_b_zero),
        .o_is_inf  (w_b_inf),
        .o_is_nan  (w_b_nan),
        .o_sign    (w_b_sign),
        .o_mag     (w_b_mag)
    );

    assign w_mag_gt = (w_a_mag > w_b_mag);
    assign w_mag_eq = (w_a_mag == w_b_mag);

    // ------------------------------------------------------------------
    // Stage-1 view: registered for PIPE=2, straight wires for PIPE=1
    // ------------------------------------------------------------------
    logic            w_s1_valid;
    logic [2:0]      w_s1_op;
    logic [TAGW-1:0] w_s1_tag;
    logic [c_W-1:0]  w_s1_a, w_s1_b;
    logic            w_s1_a_zero, w_s1_a_inf, w_s1_a_nan, w_s1_a_sign;
    logic            w_s1_b_zero, w_s1_b_inf, w_s1_b_nan, w_s1_b_sign;
    logic            w_s1_mag_gt, w_s1_mag_eq;

    generate
        if (PIPE == 2) begin : g_pipe2
            logic            r_s1_valid;
            logic [2:0]      r_s1_op;
            logic [TAGW-1:0] r_s1_tag;
            logic [c_W-1:0]  r_s1_a, r_s1_b;
            logic            r_s1_a_zero, r_s1_a_inf, r_s1_a_nan, r_s1_a_sign;
            logic            r_s1_b_zero, r_s1_b_inf, r_s1_b_nan, r_s1_b_sign;
            logic            r_s1_mag_gt, r_s1_mag_eq;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_valid  <= 1'b0;
                    r_s1_op     <= '0;
                    r_s1_tag    <= '0;
                    r_s1_a      <= '0;
                    r_s1_b      <= '0;
                    r_s1_a_zero <= 1'b0;
                    r_s1_a_inf  <= 1'b0;
                    r_s1_a_nan  <= 1'b0;
                    r_s1_a_sign <= 1'b0;
                    r_s1_b_zero <= 1'b0;
                    r_s1_b_inf  <= 1'b0;
                    r_s1_b_nan  <= 1'b0;
                    r_s1_b_sign <= 1'b0;
                    r_s1_mag_gt <= 1'b0;
                    r_s1_mag_eq <= 1'b0;
                end else if (ce) begin
                    r_s1_valid  <= in_valid;
                    r_s1_op     <= op;
                    r_s1_tag    <= in_tag;
                    r_s1_a      <= inA;
                    r_s1_b      <= inB;
                    r_s1_a_zero <= w_a_zero;
                    r_s1_a_inf  <= w_a_inf;
                    r_s1_a_nan  <= w_a_nan;
                    r_s1_a_sign <= w_a_sign;
                    r_s1_b_zero <= w_b_zero;
                    r_s1_b_inf  <= w_b_inf;
                    r_s1_b_nan  <= w_b_nan;
                    r_s1_b_sign <= w_b_sign;
                    r_s1_mag_gt <= w_mag_gt;
                    r_s1_mag_eq <= w_mag_eq;
                end
            end

            assign w_s1_valid  = r_s1_valid;
            assign w_s1_op     = r_s1_op;
            assign w_s1_tag    = r_s1_tag;
            assign w_s1_a      = r_s1_a;
            assign w_s1_b      = r_s1_b;
            assign w_s1_a_zero = r_s1_a_zero;
            assign w_s1_a_inf  = r_s1_a_inf;
            assign w_s1_a_nan  = r_s1_a_nan;
            assign w_s1_a_sign = r_s1_a_sign;
            assign w_s1_b_zero = r_s1_b_zero;
            assign w_s1_b_inf  = r_s1_b_inf;
            assign w_s1_b_nan  = r_s1_b_nan;
            assign w_s1_b_sign = r_s1_b_sign;
            assign w_s1_mag_gt = r_s1_mag_gt;
            assign w_s1_mag_eq = r_s1_mag_eq;
        end else if (PIPE == 1) begin : g_pipe1
            assign w_s1_valid  = in_valid;
            assign w_s1_op     = op;
            assign w_s1_tag    = in_tag;
            assign w_s1_a      = inA;
            assign w_s1_b      = inB;
            assign w_s1_a_zero = w_a_zero;
            assign w_s1_a_inf  = w_a_inf;
            assign w_s1_a_nan  = w_a_nan;
            assign w_s1_a_sign = w_a_sign;
            assign w_s1_b_zero = w_b_zero;
            assign w_s1_b_inf  = w_b_inf;
            assign w_s1_b_nan  = w_b_nan;
            assign w_s1_b_sign = w_b_sign;
            assign w_s1_mag_gt = w_mag_gt;
            assign w_s1_mag_eq = w_mag_eq;
        end else begin : g_bad_pipe
            $error("fp_compare_pipe: PIPE must be 1 or 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Ordering of A relative to B, ignoring NaN (NaN overrides below)
    // ------------------------------------------------------------------
    logic w_gt, w_eq, w_lt;

    always_comb begin
        w_gt = 1'b0;
        w_eq = 1'b0;
        if (w_s1_a_inf || w_s1_b_inf) begin
            if (w_s1_a_inf && w_s1_b_inf) begin
                w_eq = (w_s1_a_sign == w_s1_b_sign);
                w_gt = !w_s1_a_sign && w_s1_b_sign;
            end else if (w_s1_a_inf) begin
                w_gt = !w_s1_a_sign;
            end else begin
                // B infinite, A finite: A wins only against -inf
                w_gt = w_s1_b_sign;
            end
        end else if (w_s1_a_zero && w_s1_b_zero) begin
            w_eq = 1'b1;                 // +0 == -0
        end else if (w_s1_a_zero) begin
            w_gt = w_s1_b_sign;          // zero beats negative normals
        end else if (w_s1_b_zero) begin
            w_gt = !w_s1_a_sign;
        end else if (w_s1_a_sign != w_s1_b_sign) begin
            w_gt = !w_s1_a_sign;
        end else if (!w_s1_a_sign) begin
            w_gt = w_s1_mag_gt;
            w_eq = w_s1_mag_eq;
        end else begin
            // Both negative: larger magnitude is the smaller value
            w_gt = !w_s1_mag_gt && !w_s1_mag_eq;
            w_eq = w_s1_mag_eq;
        end
    end

    assign w_lt = !w_gt && !w_eq;

    // ------------------------------------------------------------------
    // Op mux and operand selection
    // ------------------------------------------------------------------
    logic w_unord;
    logic w_pick_max, w_pick_min;
    logic w_result;
    logic w_sel_a;

    assign w_unord = w_s1_a_nan || w_s1_b_nan;

    // NaN avoidance: a single NaN loses to the other operand, two NaNs
    // keep A. Ties keep A.
    always_comb begin
        w_pick_max = w_gt || w_eq;
        w_pick_min = w_lt || w_eq;
        if (w_s1_a_nan && w_s1_b_nan) begin
            w_pick_max = 1'b1;
            w_pick_min = 1'b1;
        end else if (w_s1_a_nan) begin
            w_pick_max = 1'b0;
            w_pick_min = 1'b0;
        end else if (w_s1_b_nan) begin
            w_pick_max = 1'b1;
            w_pick_min = 1'b1;
        end
    end

    always_comb begin
        w_result = 1'b0;
        case (w_s1_op)
            OP_GT:   w_result = !w_unord && w_gt;
            OP_GE:   w_result = !w_unord && (w_gt || w_eq);
            OP_LT:   w_result = !w_unord && w_lt;
            OP_LE:   w_result = !w_unord && (w_lt || w_eq);
            OP_EQ:   w_result = !w_unord && w_eq;
            OP_NE:   w_result = w_unord || !w_eq;
            OP_MAX:  w_result = w_pick_max;
            OP_MIN:  w_result = w_pick_min;
            default: w_result = 1'b0;
        endcase
    end

    // Predicates report the larger operand, so only MIN uses the min pick
    assign w_sel_a = (w_s1_op == OP_MIN) ? w_pick_min : w_pick_max;

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic            r_out_valid;
    logic            r_result;
    logic            r_unordered;
    logic [c_W-1:0]  r_sel_val;
    logic [TAGW-1:0] r_out_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= 1'b0;
            r_unordered <= 1'b0;
            r_sel_val   <= '0;
            r_out_tag   <= '0;
        end else if (ce) begin
            r_out_valid <= w_s1_valid;
            r_result    <= w_result;
            r_unordered <= w_unord;
            r_sel_val   <= w_sel_a ? w_s1_a : w_s1_b;
            r_out_tag   <= w_s1_tag;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign unordered = r_unordered;
    assign sel_val   = r_sel_val;
    assign out_tag   = r_out_tag;

endmodule : fp_compare_pipe
`default_nettype wire
